// File: rtl/udma_adc_rx_pp_reg_if_pkg.sv
// Shared register map, field positions and channel FSM states for the
// ping-pong ADC rx register bank.
package udma_adc_rx_pkg;

  localparam logic [2:0] REG_SADDR_A   = 3'd0;
  localparam logic [2:0] REG_SIZE      = 3'd1;
  localparam logic [2:0] REG_CFG       = 3'd2;
  localparam logic [2:0] REG_SADDR_B   = 3'd3;
  localparam logic [2:0] REG_SINGLE_CH = 3'd4;
  localparam logic [2:0] REG_STATUS    = 3'd5;
  localparam logic [2:0] REG_IRQ_EN    = 3'd6;

  localparam int CFG_CONT_BIT = 0;
  localparam int CFG_EN_BIT   = 4;
  localparam int CFG_CLR_BIT  = 5;
  localparam int CFG_PP_BIT   = 6;

  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_OVR_BIT  = 1;

  localparam logic [1:0] DATASIZE_32 = 2'b10;

  typedef enum logic [1:0] {
    PP_IDLE  = 2'd0,
    PP_RUN_A = 2'd1,
    PP_RUN_B = 2'd2
  } pp_state_e;

endpackage

// File: rtl/udma_adc_rx_pp_reg_if_if.sv
// uDMA configuration bus: single-cycle strobe, combinational read data.
interface udma_adc_rx_cfg_if;
  logic [31:0] cfg_data_i;
  logic [7:0]  cfg_addr_i;
  logic        cfg_valid_i;
  logic        cfg_rwn_i;
  logic [31:0] cfg_data_o;
  logic        cfg_ready_o;

  modport master (output cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
                  input  cfg_data_o, cfg_ready_o);
  modport slave  (input  cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
                  output cfg_data_o, cfg_ready_o);
endinterface

// File: rtl/udma_adc_rx_pp_reg_if_ch.sv
// One rx channel: config regs, ping-pong re-arm FSM, completion detect, W1C status.
//   state    | meaning
//   PP_IDLE  | not ping-ponging (off, cleared, or single-buffer mode)
//   PP_RUN_A | DMA running on buffer A, re-arm to B on completion
//   PP_RUN_B | DMA running on buffer B, re-arm to A on completion
module udma_adc_rx_pp_ch
  import udma_adc_rx_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL  = 19,
  parameter int UDMA_TRANS_SIZE = 20,
  parameter int TRANS_SIZE      = 16
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       wr_i,
  input  logic [2:0]                 reg_i,
  input  logic [31:0]                wdata_i,
  output logic [31:0]                rdata_o,
  input  logic                       rx_en_i,
  input  logic                       rx_pending_i,
  input  logic [L2_AWIDTH_NOAL-1:0]  curr_addr_i,
  input  logic [UDMA_TRANS_SIZE-1:0] bytes_left_i,
  output logic [L2_AWIDTH_NOAL-1:0]  startaddr_o,
  output logic [UDMA_TRANS_SIZE-1:0] size_o,
  output logic                       continuous_o,
  output logic                       en_o,
  output logic                       clr_o,
  output logic                       evt_done_o
);

  logic [L2_AWIDTH_NOAL-1:0] r_saddr_a, r_saddr_b;
  logic [TRANS_SIZE-1:0]     r_size, r_size_out;
  logic                      r_cont, r_pp, r_irq_en;
  logic                      r_done, r_ovr, r_buf_idx, r_en_q;
  pp_state_e                 state_q, state_d;
  logic                      arm, arm_b, clr_req, done_c;
  logic                      unused_wdata;

  wire wr_saddr_a = wr_i & (reg_i == REG_SADDR_A);
  wire wr_size    = wr_i & (reg_i == REG_SIZE);
  wire wr_cfg     = wr_i & (reg_i == REG_CFG);
  wire wr_saddr_b = wr_i & (reg_i == REG_SADDR_B);
  wire wr_status  = wr_i & (reg_i == REG_STATUS);
  wire wr_irq     = wr_i & (reg_i == REG_IRQ_EN);
  wire w1c_done   = wr_status & wdata_i[STAT_DONE_BIT];
  wire w1c_ovr    = wr_status & wdata_i[STAT_OVR_BIT];

  assign unused_wdata = ^wdata_i;
  assign done_c       = r_en_q & ~rx_en_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_saddr_a <= '0;
      r_saddr_b <= '0;
      r_size    <= '0;
      r_cont    <= 1'b0;
      r_pp      <= 1'b0;
      r_irq_en  <= 1'b0;
    end else begin
      if (wr_saddr_a) r_saddr_a <= wdata_i[L2_AWIDTH_NOAL-1:0];
      if (wr_saddr_b) r_saddr_b <= wdata_i[L2_AWIDTH_NOAL-1:0];
      if (wr_size)    r_size    <= wdata_i[TRANS_SIZE-1:0];
      if (wr_irq)     r_irq_en  <= wdata_i[0];
      if (wr_cfg) begin
        r_cont <= wdata_i[CFG_CONT_BIT];
        r_pp   <= wdata_i[CFG_PP_BIT];
      end
    end
  end

  // A software enable/clear owns the channel for that cycle; auto re-arm only otherwise.
  always_comb begin
    state_d = state_q;
    arm     = 1'b0;
    arm_b   = 1'b0;
    clr_req = 1'b0;
    if (wr_cfg && wdata_i[CFG_CLR_BIT]) begin
      state_d = PP_IDLE;
      clr_req = 1'b1;
    end else if (wr_cfg && wdata_i[CFG_EN_BIT]) begin
      arm     = 1'b1;
      state_d = wdata_i[CFG_PP_BIT] ? PP_RUN_A : PP_IDLE;
    end else if (done_c) begin
      case (state_q)
        PP_RUN_A: begin arm = 1'b1; arm_b = 1'b1; state_d = PP_RUN_B; end
        PP_RUN_B: begin arm = 1'b1; state_d = PP_RUN_A; end
        default:  state_d = PP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= PP_IDLE;
      r_en_q      <= 1'b0;
      en_o        <= 1'b0;
      clr_o       <= 1'b0;
      evt_done_o  <= 1'b0;
      startaddr_o <= '0;
      r_size_out  <= '0;
      r_buf_idx   <= 1'b0;
      r_done      <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_en_q     <= rx_en_i;
      en_o       <= arm;
      clr_o      <= clr_req;
      evt_done_o <= done_c & r_irq_en;
      if (arm) begin
        startaddr_o <= arm_b ? r_saddr_b : r_saddr_a;
        r_size_out  <= r_size;
        r_buf_idx   <= arm_b;
      end else if (clr_req) begin
        r_buf_idx   <= 1'b0;
      end
      if (done_c)        r_done <= 1'b1;
      else if (w1c_done) r_done <= 1'b0;
      if (done_c && r_done && !w1c_done) r_ovr <= 1'b1;
      else if (w1c_ovr)                  r_ovr <= 1'b0;
    end
  end

  assign size_o       = UDMA_TRANS_SIZE'(r_size_out);
  assign continuous_o = r_cont & ~r_pp;

  always_comb begin
    rdata_o = '0;
    case (reg_i)
      REG_SADDR_A: rdata_o = 32'(curr_addr_i);
      REG_SIZE:    rdata_o = 32'(bytes_left_i);
      REG_CFG:     rdata_o = {25'd0, r_pp, rx_pending_i, rx_en_i, 1'b0, DATASIZE_32, r_cont};
      REG_SADDR_B: rdata_o = 32'(r_saddr_b);
      REG_STATUS:  rdata_o = {29'd0, r_buf_idx, r_ovr, r_done};
      REG_IRQ_EN:  rdata_o = {31'd0, r_irq_en};
      default:     rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/udma_adc_rx_pp_reg_if.sv
// ADC rx register bank top: channel address decode, read mux, global single-channel mode.
module udma_adc_rx_pp_reg_if
  import udma_adc_rx_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL  = 19,
  parameter int UDMA_TRANS_SIZE = 20,
  parameter int TRANS_SIZE      = 16,
  parameter int ADC_NUM_CHS     = 8
) (
  input  logic                                          clk_i,
  input  logic                                          rstn_i,
  udma_adc_rx_cfg_if.slave                              cfg,
  output logic [ADC_NUM_CHS-1:0][L2_AWIDTH_NOAL-1:0]    cfg_rx_startaddr_o,
  output logic [ADC_NUM_CHS-1:0][UDMA_TRANS_SIZE-1:0]   cfg_rx_size_o,
  output logic [ADC_NUM_CHS-1:0][1:0]                   cfg_rx_datasize_o,
  output logic [ADC_NUM_CHS-1:0]                        cfg_rx_continuous_o,
  output logic [ADC_NUM_CHS-1:0]                        cfg_rx_en_o,
  output logic [ADC_NUM_CHS-1:0]                        cfg_rx_clr_o,
  input  logic [ADC_NUM_CHS-1:0]                        cfg_rx_en_i,
  input  logic [ADC_NUM_CHS-1:0]                        cfg_rx_pending_i,
  input  logic [ADC_NUM_CHS-1:0][L2_AWIDTH_NOAL-1:0]    cfg_rx_curr_addr_i,
  input  logic [ADC_NUM_CHS-1:0][UDMA_TRANS_SIZE-1:0]   cfg_rx_bytes_left_i,
  output logic                                          cfg_single_ch_mode_o,
  output logic [ADC_NUM_CHS-1:0]                        evt_done_o
);

  logic [4:0]                   ch;
  logic [2:0]                   rg;
  logic                         ch_ok, wr;
  logic [ADC_NUM_CHS-1:0][31:0] ch_rdata;

  assign ch    = cfg.cfg_addr_i[7:3];
  assign rg    = cfg.cfg_addr_i[2:0];
  assign ch_ok = ({1'b0, ch} < 6'(ADC_NUM_CHS));
  assign wr    = cfg.cfg_valid_i & ~cfg.cfg_rwn_i & ch_ok;

  assign cfg.cfg_ready_o = 1'b1;

  for (genvar g = 0; g < ADC_NUM_CHS; g++) begin : g_ch
    assign cfg_rx_datasize_o[g] = DATASIZE_32;

    udma_adc_rx_pp_ch #(
      .L2_AWIDTH_NOAL (L2_AWIDTH_NOAL),
      .UDMA_TRANS_SIZE(UDMA_TRANS_SIZE),
      .TRANS_SIZE     (TRANS_SIZE)
    ) u_ch (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .wr_i        (wr && (ch == 5'(g))),
      .reg_i       (rg),
      .wdata_i     (cfg.cfg_data_i),
      .rdata_o     (ch_rdata[g]),
      .rx_en_i     (cfg_rx_en_i[g]),
      .rx_pending_i(cfg_rx_pending_i[g]),
      .curr_addr_i (cfg_rx_curr_addr_i[g]),
      .bytes_left_i(cfg_rx_bytes_left_i[g]),
      .startaddr_o (cfg_rx_startaddr_o[g]),
      .size_o      (cfg_rx_size_o[g]),
      .continuous_o(cfg_rx_continuous_o[g]),
      .en_o        (cfg_rx_en_o[g]),
      .clr_o       (cfg_rx_clr_o[g]),
      .evt_done_o  (evt_done_o[g])
    );
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                        cfg_single_ch_mode_o <= 1'b0;
    else if (wr && rg == REG_SINGLE_CH) cfg_single_ch_mode_o <= cfg.cfg_data_i[0];
  end

  always_comb begin
    cfg.cfg_data_o = '0;
    if (ch_ok) begin
      if (rg == REG_SINGLE_CH) begin
        cfg.cfg_data_o = {31'd0, cfg_single_ch_mode_o};
      end else begin
        for (int c = 0; c < ADC_NUM_CHS; c++)
          if (ch == 5'(c)) cfg.cfg_data_o = ch_rdata[c];
      end
    end
  end

endmodule

// File: tb/tb_udma_adc_rx_pp_reg_if.sv
// Directed bench for the ping-pong ADC rx register bank.
module tb_udma_adc_rx_pp_reg_if;
  localparam int AW  = 19;
  localparam int UW  = 20;
  localparam int NCH = 8;

  logic clk, rstn;
  udma_adc_rx_cfg_if cfg_bus ();

  logic [NCH-1:0][AW-1:0] startaddr, curr_addr;
  logic [NCH-1:0][UW-1:0] size, bytes_left;
  logic [NCH-1:0][1:0]    datasize;
  logic [NCH-1:0]         cont, en_o, clr_o, evt, rx_en, rx_pend;
  logic                   single;

  int n_tests = 0;
  int n_fail  = 0;

  udma_adc_rx_pp_reg_if #(
    .L2_AWIDTH_NOAL(AW), .UDMA_TRANS_SIZE(UW), .TRANS_SIZE(16), .ADC_NUM_CHS(NCH)
  ) dut (
    .clk_i               (clk),
    .rstn_i              (rstn),
    .cfg                 (cfg_bus.slave),
    .cfg_rx_startaddr_o  (startaddr),
    .cfg_rx_size_o       (size),
    .cfg_rx_datasize_o   (datasize),
    .cfg_rx_continuous_o (cont),
    .cfg_rx_en_o         (en_o),
    .cfg_rx_clr_o        (clr_o),
    .cfg_rx_en_i         (rx_en),
    .cfg_rx_pending_i    (rx_pend),
    .cfg_rx_curr_addr_i  (curr_addr),
    .cfg_rx_bytes_left_i (bytes_left),
    .cfg_single_ch_mode_o(single),
    .evt_done_o          (evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_wr(input int ch, input int rg, input logic [31:0] d);
    cfg_bus.cfg_valid_i = 1'b1;
    cfg_bus.cfg_rwn_i   = 1'b0;
    cfg_bus.cfg_addr_i  = {ch[4:0], rg[2:0]};
    cfg_bus.cfg_data_i  = d;
  endtask

  task automatic wr(input int ch, input int rg, input logic [31:0] d);
    @(negedge clk);
    drive_wr(ch, rg, d);
    @(negedge clk);
    cfg_bus.cfg_valid_i = 1'b0;
  endtask

  task automatic rd(input int ch, input int rg, output logic [31:0] d);
    cfg_bus.cfg_valid_i = 1'b1;
    cfg_bus.cfg_rwn_i   = 1'b1;
    cfg_bus.cfg_addr_i  = {ch[4:0], rg[2:0]};
    #1 d = cfg_bus.cfg_data_o;
    cfg_bus.cfg_valid_i = 1'b0;
    cfg_bus.cfg_rwn_i   = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d, exp;
    logic [NCH-1:0][1:0] exp_ds;
    for (int i = 0; i < NCH; i++) exp_ds[i] = 2'b10;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (startaddr !== '0 || size !== '0 || cont !== '0 || en_o !== '0 ||
        clr_o !== '0 || evt !== '0 || single !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: sa=%h sz=%h cont=%b en=%b clr=%b evt=%b single=%b, required all 0",
               startaddr, size, cont, en_o, clr_o, evt, single);
    end
    n_tests++;
    if (datasize !== exp_ds || cfg_bus.cfg_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_datasize_ready: ds=%h ready=%b, required %h / 1", datasize, cfg_bus.cfg_ready_o, exp_ds);
    end
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 8; r++) begin
        rd(c, r, d);
        exp = (r == 2) ? 32'h4 : 32'h0;
        n_tests++;
        if (d !== exp) begin
          n_fail++;
          $display("FAIL reset_read ch%0d reg%0d: got %h, required %h", c, r, d, exp);
        end
      end
  endtask

  task automatic test_pingpong();
    logic [31:0] d;
    wr(2, 0, 32'h100);
    wr(2, 3, 32'h200);
    wr(2, 1, 32'd64);
    wr(2, 6, 32'h1);
    wr(2, 2, 32'h50);
    n_tests++;
    if (en_o !== 8'h04 || startaddr[2] !== 19'h100 || size[2] !== 20'd64 || cont[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_arm_a: en=%b sa=%h sz=%0d cont=%b, required 00000100 100 64 0",
               en_o, startaddr[2], size[2], cont[2]);
    end
    rx_en[2] = 1'b1;
    @(negedge clk);
    n_tests++;
    if (en_o !== 8'h00) begin
      n_fail++;
      $display("FAIL pp_en_single_cycle: en=%b, required 00000000", en_o);
    end
    rx_en[2] = 1'b0;
    @(negedge clk);
    rd(2, 5, d);
    n_tests++;
    if (en_o !== 8'h04 || startaddr[2] !== 19'h200 || evt !== 8'h04 || d !== 32'h5) begin
      n_fail++;
      $display("FAIL pp_rearm_b: en=%b sa=%h evt=%b status=%h, required 00000100 200 00000100 5",
               en_o, startaddr[2], evt, d);
    end
    @(negedge clk);
    n_tests++;
    if (en_o !== 8'h00 || evt !== 8'h00) begin
      n_fail++;
      $display("FAIL pp_pulse_end: en=%b evt=%b, required 0 0", en_o, evt);
    end
    rx_en[2] = 1'b1;
    @(negedge clk);
    rx_en[2] = 1'b0;
    @(negedge clk);
    rd(2, 5, d);
    n_tests++;
    if (en_o !== 8'h04 || startaddr[2] !== 19'h100 || d !== 32'h3) begin
      n_fail++;
      $display("FAIL pp_overrun_rearm_a: en=%b sa=%h status=%h, required 00000100 100 3", en_o, startaddr[2], d);
    end
    wr(2, 5, 32'h3);
    rd(2, 5, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL pp_w1c: status=%h, required 0", d);
    end
  endtask

  task automatic test_clr_same_cycle();
    logic [31:0] d;
    rx_en[2] = 1'b1;
    @(negedge clk);
    rx_en[2] = 1'b0;
    drive_wr(2, 2, 32'h70);
    @(negedge clk);
    cfg_bus.cfg_valid_i = 1'b0;
    rd(2, 5, d);
    n_tests++;
    if (clr_o !== 8'h04 || en_o !== 8'h00 || d !== 32'h1) begin
      n_fail++;
      $display("FAIL clr_beats_en: clr=%b en=%b status=%h, required 00000100 00000000 1", clr_o, en_o, d);
    end
    @(negedge clk);
    n_tests++;
    if (clr_o !== 8'h00) begin
      n_fail++;
      $display("FAIL clr_single_cycle: clr=%b, required 0", clr_o);
    end
    // idle channel completes again while software clears done in the same cycle
    rx_en[2] = 1'b1;
    @(negedge clk);
    rx_en[2] = 1'b0;
    drive_wr(2, 5, 32'h1);
    @(negedge clk);
    cfg_bus.cfg_valid_i = 1'b0;
    rd(2, 5, d);
    n_tests++;
    if (en_o !== 8'h00 || startaddr[2] !== 19'h100 || d !== 32'h1) begin
      n_fail++;
      $display("FAIL idle_w1c_vs_done: en=%b sa=%h status=%h, required 0 100 1", en_o, startaddr[2], d);
    end
  endtask

  task automatic test_single_buffer();
    logic [31:0] d;
    wr(1, 0, 32'h40);
    wr(1, 2, 32'h11);
    n_tests++;
    if (en_o !== 8'h02 || startaddr[1] !== 19'h40 || cont[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_arm_cont: en=%b sa=%h cont=%b, required 00000010 40 1", en_o, startaddr[1], cont[1]);
    end
    wr(1, 2, 32'h41);
    n_tests++;
    if (cont[1] !== 1'b0 || en_o !== 8'h00) begin
      n_fail++;
      $display("FAIL pp_kills_cont: cont=%b en=%b, required 0 0", cont[1], en_o);
    end
    rx_en[1] = 1'b1;
    @(negedge clk);
    rx_en[1] = 1'b0;
    @(negedge clk);
    rd(1, 5, d);
    n_tests++;
    if (en_o !== 8'h00 || evt !== 8'h00 || d !== 32'h1) begin
      n_fail++;
      $display("FAIL sb_done_no_irq: en=%b evt=%b status=%h, required 0 0 1", en_o, evt, d);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d0, d2, d7;
    wr(31, 0, 32'hABC);
    wr(31, 2, 32'h30);
    n_tests++;
    if (en_o !== 8'h00 || clr_o !== 8'h00) begin
      n_fail++;
      $display("FAIL ch31_write_ignored: en=%b clr=%b, required 0 0", en_o, clr_o);
    end
    wr(0, 7, 32'hFFFF_FFFF);
    rd(31, 0, d0);
    rd(31, 2, d2);
    rd(0, 7, d7);
    n_tests++;
    if (d0 !== 32'h0 || d2 !== 32'h0 || d7 !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped_reads: ch31r0=%h ch31r2=%h ch0r7=%h, required 0 0 0", d0, d2, d7);
    end
  endtask

  task automatic test_single_ch_and_readback();
    logic [31:0] d;
    wr(0, 4, 32'h1);
    rd(3, 4, d);
    n_tests++;
    if (single !== 1'b1 || d !== 32'h1) begin
      n_fail++;
      $display("FAIL single_ch_set: out=%b read=%h, required 1 1", single, d);
    end
    curr_addr[3]  = 19'h1234;
    bytes_left[3] = 20'hABCDE;
    rx_pend[3]    = 1'b1;
    rd(3, 0, d);
    n_tests++;
    if (d !== 32'h1234) begin
      n_fail++;
      $display("FAIL read_curr_addr: got %h, required 1234", d);
    end
    rd(3, 1, d);
    n_tests++;
    if (d !== 32'hABCDE) begin
      n_fail++;
      $display("FAIL read_bytes_left: got %h, required abcde", d);
    end
    rd(3, 2, d);
    n_tests++;
    if (d !== 32'h24) begin
      n_fail++;
      $display("FAIL read_cfg_pending: got %h, required 24", d);
    end
    wr(3, 3, 32'hFFFF_FFFF);
    rd(3, 3, d);
    n_tests++;
    if (d !== 32'h7FFFF) begin
      n_fail++;
      $display("FAIL saddr_b_width: got %h, required 7ffff", d);
    end
    rx_pend[3] = 1'b0;
    wr(5, 4, 32'h0);
    n_tests++;
    if (single !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ch_clear: got %b, required 0", single);
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] d;
    wr(4, 0, 32'h10);
    wr(4, 2, 32'h50);
    rx_en[4] = 1'b1;
    @(negedge clk);
    rstn     = 1'b0;
    rx_en[4] = 1'b0;
    #1;
    n_tests++;
    if (startaddr !== '0 || en_o !== '0 || clr_o !== '0 || evt !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: sa=%h en=%b clr=%b evt=%b, required all 0", startaddr, en_o, clr_o, evt);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    rd(4, 5, d);
    n_tests++;
    if (en_o !== '0 || evt !== '0 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: en=%b evt=%b status=%h, required 0 0 0", en_o, evt, d);
    end
    rd(4, 2, d);
    n_tests++;
    if (d !== 32'h4) begin
      n_fail++;
      $display("FAIL reset_mid_cfg: got %h, required 4", d);
    end
  endtask

  initial begin
    rstn                = 1'b0;
    rx_en               = '0;
    rx_pend             = '0;
    curr_addr           = '0;
    bytes_left          = '0;
    cfg_bus.cfg_valid_i = 1'b0;
    cfg_bus.cfg_rwn_i   = 1'b0;
    cfg_bus.cfg_addr_i  = '0;
    cfg_bus.cfg_data_i  = '0;
    test_reset();
    test_pingpong();
    test_clr_same_cycle();
    test_single_buffer();
    test_out_of_range();
    test_single_ch_and_readback();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
